regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 36 +++
 rtl/regfile_dump_ctrl.sv | 77 +++++++
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the dump FSM state encoding and the default width constants.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dump_state_e;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

endpackage

// File: rtl/regfile_mp_if.sv
// Pipeline write/read bus and debug dump handshake of regfile_mp.
// The master drives requests; the slave (the register file) returns data.
interface regfile_mp_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NUM_RD = 2
);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic                     rd_hold;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     dbg_start;
    logic                     dbg_abort;
    logic                     dbg_valid;
    logic                     dbg_ready;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;
    logic                     dbg_last;
    logic                     dbg_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rd_hold,
        output dbg_start, dbg_abort, dbg_ready,
        input  rd_data, dbg_valid, dbg_addr, dbg_data, dbg_last, dbg_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rd_hold,
        input  dbg_start, dbg_abort, dbg_ready,
        output rd_data, dbg_valid, dbg_addr, dbg_data, dbg_last, dbg_busy
    );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer: walks idx over every register under valid/ready.
// Emits a fetch strobe/address; the owner of the storage loads the word.
module regfile_dump_ctrl
    import regfile_pkg::dump_state_e, regfile_pkg::ST_IDLE, regfile_pkg::ST_SEND;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_start,
    input  logic              dbg_abort,
    input  logic              dbg_ready,
    output logic              dbg_valid,
    output logic              dbg_busy,
    output logic              dbg_last,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic              fetch_en,
    output logic [ADDR_W-1:0] fetch_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (dbg_start) state_d = ST_SEND;
            ST_SEND: begin
                if (dbg_abort)                          state_d = ST_IDLE;
                else if (dbg_ready && idx_q == LAST_IDX) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fetch_en   = 1'b0;
        fetch_addr = idx_q;
        idx_d      = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg_start) begin
                    fetch_en   = 1'b1;
                    fetch_addr = '0;
                    idx_d      = '0;
                end
            end
            ST_SEND: begin
                // Abort wins over a simultaneous handshake: nothing advances.
                if (!dbg_abort && dbg_ready && idx_q != LAST_IDX) begin
                    fetch_en   = 1'b1;
                    fetch_addr = idx_q + 1'b1;
                    idx_d      = idx_q + 1'b1;
                end
            end
        endcase
    end

    assign dbg_busy  = (state_q == ST_SEND);
    assign dbg_valid = dbg_busy;
    assign dbg_addr  = idx_q;
    assign dbg_last  = dbg_valid && (idx_q == LAST_IDX);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with synchronous reads, write-through bypass,
// read hold and a non-intrusive debug dump port.
module regfile_mp #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic                     wr_live;
    logic [NUM_RD*DATA_W-1:0] rd_next;
    logic [NUM_RD*DATA_W-1:0] rd_q;
    logic [DATA_W-1:0]        dbg_data_q;
    logic                     fetch_en;
    logic [ADDR_W-1:0]        fetch_addr;
    logic                     dbg_valid;
    logic                     dbg_busy;
    logic                     dbg_last;
    logic [ADDR_W-1:0]        dbg_addr;

    // Value a read launched this edge must see: zero reg, then bypass, then storage.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              w_live,
        input logic [ADDR_W-1:0] w_addr,
        input logic [DATA_W-1:0] w_data
    );
        if (ZERO_REG && addr == '0)      return '0;
        else if (w_live && w_addr == addr) return w_data;
        else                              return stored;
    endfunction

    assign wr_live = bus.wr_en && !(ZERO_REG && bus.wr_addr == '0);

    // NOTE: storage is cleared on reset so a dump straight after reset sees a defined image;
    // this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_live) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        assign addr_k = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_next[k*DATA_W +: DATA_W] =
            resolve(addr_k, mem[addr_k], wr_live, bus.wr_addr, bus.wr_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            rd_q <= '0;
        else if (!bus.rd_hold) rd_q <= rd_next;
    end

    regfile_dump_ctrl #(.ADDR_W(ADDR_W)) u_dump (
        .clk        (clk),
        .rst_n      (rst_n),
        .dbg_start  (bus.dbg_start),
        .dbg_abort  (bus.dbg_abort),
        .dbg_ready  (bus.dbg_ready),
        .dbg_valid  (dbg_valid),
        .dbg_busy   (dbg_busy),
        .dbg_last   (dbg_last),
        .dbg_addr   (dbg_addr),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr)
    );

    // The dump word is only reloaded on a fetch, so it holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data_q <= '0;
        end else if (fetch_en) begin
            dbg_data_q <= resolve(fetch_addr, mem[fetch_addr], wr_live,
                                  bus.wr_addr, bus.wr_data);
        end
    end

    assign bus.rd_data   = rd_q;
    assign bus.dbg_valid = dbg_valid;
    assign bus.dbg_busy  = dbg_busy;
    assign bus.dbg_last  = dbg_last;
    assign bus.dbg_addr  = dbg_addr;
    assign bus.dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rd  [NR];
    bit            m_busy;
    int            m_idx;
    logic [DW-1:0] m_data;
    bit            cmp_on = 1'b0;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } xfer_t;
    xfer_t xq[$];

    function automatic logic [DW-1:0] m_val(input logic [AW-1:0] a);
        if (a == 0)                              return '0;
        if (bus.wr_en && bus.wr_addr == a)       return bus.wr_data;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int k = 0; k < NR; k++) m_rd[k] = '0;
        m_busy = 1'b0;
        m_idx  = 0;
        m_data = '0;
    endtask

    task automatic model_step();
        if (!bus.rd_hold)
            for (int k = 0; k < NR; k++) m_rd[k] = m_val(bus.rd_addr[k*AW +: AW]);
        if (!m_busy) begin
            if (bus.dbg_start) begin
                m_busy = 1'b1;
                m_idx  = 0;
                m_data = m_val(0);
            end
        end else if (bus.dbg_abort) begin
            m_busy = 1'b0;
        end else if (bus.dbg_ready) begin
            if (m_idx == DEPTH - 1) m_busy = 1'b0;
            else begin
                m_idx  = m_idx + 1;
                m_data = m_val(AW'(m_idx));
            end
        end
        if (bus.wr_en && bus.wr_addr != 0) m_mem[bus.wr_addr] = bus.wr_data;
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.dbg_valid && bus.dbg_ready && !bus.dbg_abort)
                xq.push_back('{addr: int'(bus.dbg_addr), data: bus.dbg_data});
            model_step();
        end
    end

    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            for (int k = 0; k < NR; k++)
                check($sformatf("rd_data[%0d]", k), bus.rd_data[k*DW +: DW], m_rd[k]);
            check("dbg_valid", bus.dbg_valid, m_busy);
            check("dbg_busy", bus.dbg_busy, m_busy);
            check("dbg_last", bus.dbg_last, m_busy && m_idx == DEPTH - 1);
            if (m_busy) begin
                check("dbg_addr", bus.dbg_addr, m_idx);
                check("dbg_data", bus.dbg_data, m_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr   = '0;
        bus.rd_hold   = 1'b0;
        bus.dbg_start = 1'b0;
        bus.dbg_abort = 1'b0;
        bus.dbg_ready = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        while (int'(bus.dbg_addr) != a && n < 200) begin
            tick();
            n++;
        end
        check("wait_addr", bus.dbg_addr, a);
    endtask

    task automatic drain_dump(input bit random_ready);
        int n = 0;
        while (bus.dbg_busy && n < 1000) begin
            bus.dbg_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        bus.dbg_ready = 1'b0;
        check("dump_done_busy", bus.dbg_busy, 0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        idle_inputs();
        model_reset();

        #12;
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_dbg_valid", bus.dbg_valid, 0);
        check("rst_dbg_busy", bus.dbg_busy, 0);
        check("rst_dbg_last", bus.dbg_last, 0);
        check("rst_dbg_addr", bus.dbg_addr, 0);
        check("rst_dbg_data", bus.dbg_data, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Reads before any write return zero; write r5 then read it.
        set_rd(5'd5, 5'd9);
        tick();
        check("pre_write_p0", bus.rd_data[DW-1:0], 0);
        check("pre_write_p1", bus.rd_data[2*DW-1:DW], 0);
        set_rd(5'd0, 5'd0);
        write_reg(5'd5, 32'hDEAD_BEEF);
        set_rd(5'd5, 5'd0);
        tick();
        check("r5_read", bus.rd_data[DW-1:0], 32'hDEAD_BEEF);

        // Same-edge bypass on port 1, then a dropped write to r0.
        set_rd(5'd0, 5'd7);
        write_reg(5'd7, 32'h1234_5678);
        check("bypass_p1", bus.rd_data[2*DW-1:DW], 32'h1234_5678);
        set_rd(5'd0, 5'd0);
        write_reg(5'd0, 32'hFFFF_FFFF);
        check("r0_bypass", bus.rd_data[DW-1:0], 0);
        tick();
        check("r0_stored", bus.rd_data[DW-1:0], 0);

        // Hold freezes the ports while writes continue.
        write_reg(5'd3, 32'hA);
        set_rd(5'd3, 5'd3);
        tick();
        check("hold_pre", bus.rd_data[DW-1:0], 32'hA);
        bus.rd_hold = 1'b1;
        write_reg(5'd3, 32'hB);
        check("hold_frozen0", bus.rd_data[DW-1:0], 32'hA);
        tick();
        check("hold_frozen1", bus.rd_data[DW-1:0], 32'hA);
        bus.rd_hold = 1'b0;
        tick();
        check("hold_release", bus.rd_data[DW-1:0], 32'hB);

        // Full dump with random back-pressure.
        for (int i = 0; i < DEPTH; i++) write_reg(AW'(i), DW'(i * 3));
        xq.delete();
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        check("dump_first_valid", bus.dbg_valid, 1);
        check("dump_first_addr", bus.dbg_addr, 0);
        drain_dump(1'b1);
        check("dump_count", xq.size(), DEPTH);
        foreach (xq[i]) begin
            check($sformatf("dump_addr_%0d", i), xq[i].addr, i);
            check($sformatf("dump_data_%0d", i), xq[i].data, i * 3);
        end

        // Stalled word survives a write; a same-edge rewrite is fetched.
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        bus.dbg_ready = 1'b1;
        wait_addr(10);
        bus.dbg_ready = 1'b0;
        write_reg(5'd10, 32'h55);
        tick();
        check("stall_addr", bus.dbg_addr, 10);
        check("stall_data", bus.dbg_data, 30);
        bus.dbg_ready = 1'b1;
        write_reg(5'd11, 32'h77);
        check("fetch_bypass_addr", bus.dbg_addr, 11);
        check("fetch_bypass_data", bus.dbg_data, 32'h77);
        drain_dump(1'b0);

        // Abort at addr 8 (ready also high), restart, then reset at addr 20.
        xq.delete();
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        bus.dbg_ready = 1'b1;
        wait_addr(8);
        bus.dbg_abort = 1'b1;
        tick();
        bus.dbg_abort = 1'b0;
        bus.dbg_ready = 1'b0;
        check("abort_valid", bus.dbg_valid, 0);
        check("abort_busy", bus.dbg_busy, 0);
        check("abort_xfers", xq.size(), 8);
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        check("restart_valid", bus.dbg_valid, 1);
        check("restart_addr", bus.dbg_addr, 0);
        bus.dbg_ready = 1'b1;
        wait_addr(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rd_data", bus.rd_data, 0);
        check("midrst_valid", bus.dbg_valid, 0);
        check("midrst_busy", bus.dbg_busy, 0);
        check("midrst_last", bus.dbg_last, 0);
        check("midrst_addr", bus.dbg_addr, 0);
        check("midrst_data", bus.dbg_data, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        set_rd(5'd5, 5'd11);
        tick();
        check("post_rst_r5", bus.rd_data[DW-1:0], 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.wr_addr   = rand_addr();
            bus.wr_data   = $urandom;
            set_rd(rand_addr(), rand_addr());
            bus.rd_hold   = ($urandom_range(0, 4) == 0);
            bus.dbg_start = ($urandom_range(0, 9) == 0);
            bus.dbg_abort = ($urandom_range(0, 39) == 0);
            bus.dbg_ready = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
